// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ==================================================================
// reorder_buffer_pkg - ROB type codes, entry layout and default sizes
// Rev 1.0
// ==================================================================
package reorder_buffer_pkg;

  localparam int c_ROB_WIDTH      = 4;
  localparam int c_ROB_TYPE_WIDTH = 2;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic        valid;
    logic        ready;
    rob_type_e   typ;
    logic [4:0]  destReg;
    logic        predTaken;
    logic [31:0] altPc;
    logic [31:0] val;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_match.sv
`default_nettype none
// ==================================================================
// rob_broadcast_match - compares one ROB index against the rs and lsb buses
// Rev 1.0
// ==================================================================
module rob_broadcast_match
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = c_ROB_WIDTH
) (
  input  logic [ROB_WIDTH-1:0] idx_i,
  input  logic                 rs_update_i,
  input  logic [ROB_WIDTH-1:0] rs_index_i,
  input  logic [31:0]          rs_val_i,
  input  logic                 lsb_update_i,
  input  logic [ROB_WIDTH-1:0] lsb_index_i,
  input  logic [31:0]          lsb_val_i,
  output logic                 hit_o,
  output logic [31:0]          val_o
);

  logic w_rsHit;
  logic w_lsbHit;

  assign w_rsHit  = rs_update_i  && (rs_index_i  == idx_i);
  assign w_lsbHit = lsb_update_i && (lsb_index_i == idx_i);
  assign hit_o    = w_rsHit | w_lsbHit;
  // lsb has priority when both units report the same index
  assign val_o    = w_lsbHit ? lsb_val_i : (w_rsHit ? rs_val_i : 32'd0);

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ==================================================================
// reorder_buffer - circular in-order retirement queue with operand lookup
// Rev 1.0
// ==================================================================
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH      = c_ROB_WIDTH,
  parameter int ROB_TYPE_WIDTH = c_ROB_TYPE_WIDTH
) (
  input  logic                      clockIn,
  input  logic                      resetIn,
  input  logic                      addValid,
  input  logic [ROB_TYPE_WIDTH-1:0] addType,
  input  logic [4:0]                addDestReg,
  input  logic                      addPredTaken,
  input  logic [31:0]               addAltPc,
  input  logic                      addReady,
  input  logic [31:0]               addVal,
  output logic [ROB_WIDTH-1:0]      robTail,
  output logic                      full,
  input  logic [ROB_WIDTH-1:0]      query1Index,
  input  logic [ROB_WIDTH-1:0]      query2Index,
  output logic                      query1Ready,
  output logic                      query2Ready,
  output logic [31:0]               query1Val,
  output logic [31:0]               query2Val,
  input  logic                      rsUpdate,
  input  logic [ROB_WIDTH-1:0]      rsRobIndex,
  input  logic [31:0]               rsVal,
  input  logic                      lsbUpdate,
  input  logic [ROB_WIDTH-1:0]      lsbRobIndex,
  input  logic [31:0]               lsbVal,
  output logic                      regWrite,
  output logic [4:0]                regIndex,
  output logic [ROB_WIDTH-1:0]      regRobIndex,
  output logic [31:0]               regVal,
  output logic                      storeCommit,
  output logic [ROB_WIDTH-1:0]      storeRobIndex,
  output logic                      clear,
  output logic [31:0]               clearPc
);

  localparam int                 c_ENTRIES = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] c_FULL_AT = {1'b0, {ROB_WIDTH{1'b1}}};

  rob_entry_t           entries_q [c_ENTRIES];
  logic [ROB_WIDTH-1:0] head_q, tail_q;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic                 full_q;
  logic                 regWrite_q, storeCommit_q, clear_q;
  logic [4:0]           regIndex_q;
  logic [ROB_WIDTH-1:0] regRobIndex_q, storeRobIndex_q;
  logic [31:0]          regVal_q, clearPc_q;

  logic                 w_rsUpd, w_lsbUpd, w_add, w_retire, w_mispredict;
  rob_entry_t           w_head;
  logic [c_ENTRIES-1:0] w_hit;
  logic [31:0]          w_hitVal [c_ENTRIES];
  logic [ROB_WIDTH-1:0] w_qIdx [2];
  logic                 w_qHit [2];
  logic [31:0]          w_qHitVal [2];
  logic                 w_qReady [2];
  logic [31:0]          w_qVal [2];

  // Nothing is accepted during the cycle the flush pulse is visible
  assign w_rsUpd  = rsUpdate  & ~clear_q;
  assign w_lsbUpd = lsbUpdate & ~clear_q;
  assign w_add    = addValid  & ~clear_q;

  assign w_head       = entries_q[head_q];
  assign w_retire     = w_head.valid & w_head.ready & ~clear_q;
  assign w_mispredict = w_retire & (w_head.typ == ROB_BRANCH) & (w_head.val[0] != w_head.predTaken);
  assign count_d      = count_q + {{ROB_WIDTH{1'b0}}, w_add} - {{ROB_WIDTH{1'b0}}, w_retire};

  for (genvar i = 0; i < c_ENTRIES; i++) begin : g_entry
    rob_broadcast_match #(.ROB_WIDTH(ROB_WIDTH)) u_match (
      .idx_i       (ROB_WIDTH'(i)),
      .rs_update_i (w_rsUpd),
      .rs_index_i  (rsRobIndex),
      .rs_val_i    (rsVal),
      .lsb_update_i(w_lsbUpd),
      .lsb_index_i (lsbRobIndex),
      .lsb_val_i   (lsbVal),
      .hit_o       (w_hit[i]),
      .val_o       (w_hitVal[i])
    );
  end

  assign w_qIdx[0] = query1Index;
  assign w_qIdx[1] = query2Index;

  for (genvar q = 0; q < 2; q++) begin : g_query
    rob_broadcast_match #(.ROB_WIDTH(ROB_WIDTH)) u_match (
      .idx_i       (w_qIdx[q]),
      .rs_update_i (w_rsUpd),
      .rs_index_i  (rsRobIndex),
      .rs_val_i    (rsVal),
      .lsb_update_i(w_lsbUpd),
      .lsb_index_i (lsbRobIndex),
      .lsb_val_i   (lsbVal),
      .hit_o       (w_qHit[q]),
      .val_o       (w_qHitVal[q])
    );
    assign w_qReady[q] = w_qHit[q] | entries_q[w_qIdx[q]].ready;
    assign w_qVal[q]   = w_qHit[q] ? w_qHitVal[q] :
                         (entries_q[w_qIdx[q]].ready ? entries_q[w_qIdx[q]].val : 32'd0);
  end

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      for (int i = 0; i < c_ENTRIES; i++) entries_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      full_q          <= 1'b0;
      regWrite_q      <= 1'b0;
      regIndex_q      <= '0;
      regRobIndex_q   <= '0;
      regVal_q        <= '0;
      storeCommit_q   <= 1'b0;
      storeRobIndex_q <= '0;
      clear_q         <= 1'b0;
      clearPc_q       <= '0;
    end else begin
      regWrite_q      <= 1'b0;
      regIndex_q      <= '0;
      regRobIndex_q   <= '0;
      regVal_q        <= '0;
      storeCommit_q   <= 1'b0;
      storeRobIndex_q <= '0;
      clear_q         <= 1'b0;
      clearPc_q       <= '0;
      if (w_mispredict) begin
        for (int i = 0; i < c_ENTRIES; i++) begin
          entries_q[i].valid <= 1'b0;
          entries_q[i].ready <= 1'b0;
        end
        head_q    <= '0;
        tail_q    <= '0;
        count_q   <= '0;
        full_q    <= 1'b0;
        clear_q   <= 1'b1;
        clearPc_q <= w_head.altPc;
      end else begin
        for (int i = 0; i < c_ENTRIES; i++) begin
          if (entries_q[i].valid && w_hit[i]) begin
            entries_q[i].ready <= 1'b1;
            entries_q[i].val   <= w_hitVal[i];
          end
        end
        // Retire clears the head after the broadcast loop so it takes precedence
        if (w_retire) begin
          entries_q[head_q].valid <= 1'b0;
          entries_q[head_q].ready <= 1'b0;
          head_q                  <= head_q + ROB_WIDTH'(1);
          if (w_head.typ == ROB_REG) begin
            regWrite_q    <= (w_head.destReg != 5'd0);
            regIndex_q    <= w_head.destReg;
            regRobIndex_q <= head_q;
            regVal_q      <= w_head.val;
          end
          if (w_head.typ == ROB_STORE) begin
            storeCommit_q   <= 1'b1;
            storeRobIndex_q <= head_q;
          end
        end
        if (w_add) begin
          entries_q[tail_q] <= '{valid: 1'b1, ready: addReady, typ: rob_type_e'(addType[1:0]),
                                 destReg: addDestReg, predTaken: addPredTaken, altPc: addAltPc,
                                 val: (addReady ? addVal : 32'd0)};
          tail_q <= tail_q + ROB_WIDTH'(1);
        end
        count_q <= count_d;
        full_q  <= (count_d >= c_FULL_AT);
      end
    end
  end

  assign robTail       = tail_q;
  assign full          = full_q;
  assign query1Ready   = w_qReady[0];
  assign query2Ready   = w_qReady[1];
  assign query1Val     = w_qVal[0];
  assign query2Val     = w_qVal[1];
  assign regWrite      = regWrite_q;
  assign regIndex      = regIndex_q;
  assign regRobIndex   = regRobIndex_q;
  assign regVal        = regVal_q;
  assign storeCommit   = storeCommit_q;
  assign storeRobIndex = storeRobIndex_q;
  assign clear         = clear_q;
  assign clearPc       = clearPc_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ==================================================================
// tb_reorder_buffer - directed vector table plus multi-cycle sequences
// Rev 1.0
// ==================================================================
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        addValid, addPredTaken, addReady;
  logic [1:0]  addType;
  logic [4:0]  addDestReg;
  logic [31:0] addAltPc, addVal;
  logic [3:0]  robTail, query1Index, query2Index, rsRobIndex, lsbRobIndex, regRobIndex, storeRobIndex;
  logic        full, query1Ready, query2Ready, rsUpdate, lsbUpdate, regWrite, storeCommit, clear;
  logic [31:0] query1Val, query2Val, rsVal, lsbVal, regVal, clearPc;
  logic [4:0]  regIndex;

  int ncmp = 0;
  int nbad = 0;

  always #5 clockIn = ~clockIn;

  reorder_buffer #(.ROB_WIDTH(4), .ROB_TYPE_WIDTH(2)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .addValid(addValid), .addType(addType), .addDestReg(addDestReg), .addPredTaken(addPredTaken),
    .addAltPc(addAltPc), .addReady(addReady), .addVal(addVal),
    .robTail(robTail), .full(full),
    .query1Index(query1Index), .query2Index(query2Index),
    .query1Ready(query1Ready), .query2Ready(query2Ready),
    .query1Val(query1Val), .query2Val(query2Val),
    .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex), .rsVal(rsVal),
    .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex), .lsbVal(lsbVal),
    .regWrite(regWrite), .regIndex(regIndex), .regRobIndex(regRobIndex), .regVal(regVal),
    .storeCommit(storeCommit), .storeRobIndex(storeRobIndex),
    .clear(clear), .clearPc(clearPc)
  );

  // Issuing into a completely occupied buffer is illegal stimulus
  always @(posedge clockIn)
    if (resetIn && addValid)
      assert (dut.count_q != 5'd16) else $error("FAIL illegal_add: issue with 16 entries held");

  typedef struct {
    string       name;
    logic        add;  logic [1:0] typ; logic [4:0] rd; logic pt; logic [31:0] alt;
    logic        rdy;  logic [31:0] aval;
    logic        rsU;  logic [3:0] rsI; logic [31:0] rsV;
    logic        lsU;  logic [3:0] lsI; logic [31:0] lsV;
    logic [3:0]  q1;   logic eQ1R; logic [31:0] eQ1V;
    logic [3:0]  q2;   logic eQ2R; logic [31:0] eQ2V;
    logic [3:0]  eTail; logic eFull;
    logic        eRegW; logic [4:0] eRegIdx; logic [3:0] eRegRob; logic [31:0] eRegVal;
    logic        eSt;  logic [3:0] eStIdx;
    logic        eClr; logic [31:0] eClrPc;
  } vec_t;

  function automatic vec_t nop(input string n, input logic [3:0] tl, input logic fl);
    vec_t v;
    v.name = n;
    v.add = 1'b0; v.typ = ROB_REG; v.rd = 5'd0; v.pt = 1'b0; v.alt = 32'd0; v.rdy = 1'b0; v.aval = 32'd0;
    v.rsU = 1'b0; v.rsI = 4'd0; v.rsV = 32'd0; v.lsU = 1'b0; v.lsI = 4'd0; v.lsV = 32'd0;
    v.q1 = 4'd15; v.eQ1R = 1'b0; v.eQ1V = 32'd0; v.q2 = 4'd15; v.eQ2R = 1'b0; v.eQ2V = 32'd0;
    v.eTail = tl; v.eFull = fl;
    v.eRegW = 1'b0; v.eRegIdx = 5'd0; v.eRegRob = 4'd0; v.eRegVal = 32'd0;
    v.eSt = 1'b0; v.eStIdx = 4'd0; v.eClr = 1'b0; v.eClrPc = 32'd0;
    return v;
  endfunction

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", n, f, act, exp);
    end
  endtask

  task automatic chk_zero(input string n);
    chk(n, "regWrite",      32'(regWrite),      32'd0);
    chk(n, "regIndex",      32'(regIndex),      32'd0);
    chk(n, "regRobIndex",   32'(regRobIndex),   32'd0);
    chk(n, "regVal",        regVal,             32'd0);
    chk(n, "storeCommit",   32'(storeCommit),   32'd0);
    chk(n, "storeRobIndex", 32'(storeRobIndex), 32'd0);
    chk(n, "clear",         32'(clear),         32'd0);
    chk(n, "clearPc",       clearPc,            32'd0);
    chk(n, "robTail",       32'(robTail),       32'd0);
    chk(n, "full",          32'(full),          32'd0);
  endtask

  // Called at a falling edge: drive, check lookups, then check registered outputs after the rise
  task automatic step(input vec_t v);
    addValid = v.add; addType = v.typ; addDestReg = v.rd; addPredTaken = v.pt;
    addAltPc = v.alt; addReady = v.rdy; addVal = v.aval;
    rsUpdate = v.rsU; rsRobIndex = v.rsI; rsVal = v.rsV;
    lsbUpdate = v.lsU; lsbRobIndex = v.lsI; lsbVal = v.lsV;
    query1Index = v.q1; query2Index = v.q2;
    #1;
    chk(v.name, "query1Ready", 32'(query1Ready), 32'(v.eQ1R));
    chk(v.name, "query1Val",   query1Val,        v.eQ1V);
    chk(v.name, "query2Ready", 32'(query2Ready), 32'(v.eQ2R));
    chk(v.name, "query2Val",   query2Val,        v.eQ2V);
    @(posedge clockIn);
    @(negedge clockIn);
    chk(v.name, "robTail",     32'(robTail),     32'(v.eTail));
    chk(v.name, "full",        32'(full),        32'(v.eFull));
    chk(v.name, "regWrite",    32'(regWrite),    32'(v.eRegW));
    chk(v.name, "storeCommit", 32'(storeCommit), 32'(v.eSt));
    chk(v.name, "clear",       32'(clear),       32'(v.eClr));
    if (v.eRegW) begin
      chk(v.name, "regIndex",    32'(regIndex),    32'(v.eRegIdx));
      chk(v.name, "regRobIndex", 32'(regRobIndex), 32'(v.eRegRob));
      chk(v.name, "regVal",      regVal,           v.eRegVal);
    end
    if (v.eSt)  chk(v.name, "storeRobIndex", 32'(storeRobIndex), 32'(v.eStIdx));
    if (v.eClr) chk(v.name, "clearPc",       clearPc,            v.eClrPc);
  endtask

  task automatic set_reg(inout vec_t v, input logic [4:0] idx, input logic [3:0] rob, input logic [31:0] val);
    v.eRegW = 1'b1; v.eRegIdx = idx; v.eRegRob = rob; v.eRegVal = val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    resetIn = 1'b0;
    v = nop("init", 4'd0, 1'b0);
    addValid = 0; addType = 0; addDestReg = 0; addPredTaken = 0; addAltPc = 0; addReady = 0; addVal = 0;
    rsUpdate = 0; rsRobIndex = 0; rsVal = 0; lsbUpdate = 0; lsbRobIndex = 0; lsbVal = 0;
    query1Index = 0; query2Index = 0;
    @(negedge clockIn);
    @(negedge clockIn);
    chk_zero("reset");
    resetIn = 1'b1;

    // One row per cycle; expectations are the state seen after that cycle's rising edge
    v = nop("issue_reg5", 4'd1, 0); v.add = 1; v.rd = 5'd5; tbl.push_back(v);
    v = nop("rs_bcast0", 4'd1, 0); v.rsU = 1; v.rsI = 0; v.rsV = 32'h1234;
    v.q1 = 0; v.eQ1R = 1; v.eQ1V = 32'h1234; v.q2 = 1; tbl.push_back(v);
    v = nop("retire0", 4'd1, 0); v.q1 = 0; v.eQ1R = 1; v.eQ1V = 32'h1234;
    set_reg(v, 5'd5, 4'd0, 32'h1234); tbl.push_back(v);
    v = nop("issue_a", 4'd2, 0); v.add = 1; v.rd = 5'd6; tbl.push_back(v);
    v = nop("issue_b", 4'd3, 0); v.add = 1; v.rd = 5'd7; tbl.push_back(v);
    v = nop("cmp2_first", 4'd3, 0); v.rsU = 1; v.rsI = 2; v.rsV = 32'd7;
    v.q1 = 2; v.eQ1R = 1; v.eQ1V = 32'd7; v.q2 = 1; tbl.push_back(v);
    v = nop("cmp1", 4'd3, 0); v.lsU = 1; v.lsI = 1; v.lsV = 32'd3;
    v.q1 = 1; v.eQ1R = 1; v.eQ1V = 32'd3; v.q2 = 2; v.eQ2R = 1; v.eQ2V = 32'd7; tbl.push_back(v);
    v = nop("ret1", 4'd3, 0); set_reg(v, 5'd6, 4'd1, 32'd3); tbl.push_back(v);
    v = nop("ret2", 4'd3, 0); set_reg(v, 5'd7, 4'd2, 32'd7); tbl.push_back(v);
    v = nop("issue_c", 4'd4, 0); v.add = 1; v.rd = 5'd8; tbl.push_back(v);
    v = nop("dual_bcast", 4'd4, 0); v.lsU = 1; v.lsI = 3; v.lsV = 32'hAB; v.rsU = 1; v.rsI = 3; v.rsV = 32'hCD;
    v.q1 = 3; v.eQ1R = 1; v.eQ1V = 32'hAB; v.q2 = 3; v.eQ2R = 1; v.eQ2V = 32'hAB; tbl.push_back(v);
    v = nop("ret3", 4'd4, 0); set_reg(v, 5'd8, 4'd3, 32'hAB); tbl.push_back(v);
    v = nop("issue_x0", 4'd5, 0); v.add = 1; v.rd = 5'd0; v.rdy = 1; v.aval = 32'h55; tbl.push_back(v);
    v = nop("ret_x0", 4'd5, 0); tbl.push_back(v);
    v = nop("issue_st", 4'd6, 0); v.add = 1; v.typ = ROB_STORE; tbl.push_back(v);
    v = nop("st_done", 4'd6, 0); v.lsU = 1; v.lsI = 5; tbl.push_back(v);
    v = nop("st_commit", 4'd6, 0); v.eSt = 1; v.eStIdx = 4'd5; tbl.push_back(v);
    v = nop("issue_br_ok", 4'd7, 0); v.add = 1; v.typ = ROB_BRANCH; v.pt = 1; v.alt = 32'h200; tbl.push_back(v);
    v = nop("br_ok_res", 4'd7, 0); v.rsU = 1; v.rsI = 6; v.rsV = 32'd1; tbl.push_back(v);
    v = nop("br_ok_ret", 4'd7, 0); tbl.push_back(v);
    v = nop("issue_br_bad", 4'd8, 0); v.add = 1; v.typ = ROB_BRANCH; v.pt = 0; v.alt = 32'h100; tbl.push_back(v);
    v = nop("issue_young", 4'd9, 0); v.add = 1; v.rd = 5'd9; v.rdy = 1; v.aval = 32'h99;
    v.rsU = 1; v.rsI = 7; v.rsV = 32'd1; tbl.push_back(v);
    v = nop("br_bad_ret", 4'd0, 0); v.add = 1; v.rd = 5'd10; v.rdy = 1; v.aval = 32'hA0;
    v.eClr = 1; v.eClrPc = 32'h100; tbl.push_back(v);
    v = nop("clear_cycle", 4'd0, 0); v.add = 1; v.rd = 5'd11; v.rdy = 1; v.aval = 32'hB0;
    v.rsU = 1; v.rsI = 0; v.rsV = 32'd5; tbl.push_back(v);
    v = nop("post_flush", 4'd0, 0); v.q1 = 8; tbl.push_back(v);

    foreach (tbl[i]) step(tbl[i]);

    // Fill to the full threshold, retire one, then wrap the tail past index 15
    for (int i = 0; i < 15; i++) begin
      v = nop("fill", 4'(i + 1), (i == 14)); v.add = 1; v.rd = 5'(i + 1);
      step(v);
    end
    v = nop("fill_cmp0", 4'd15, 1); v.rsU = 1; v.rsI = 0; v.rsV = 32'h77;
    v.q1 = 0; v.eQ1R = 1; v.eQ1V = 32'h77; step(v);
    v = nop("fill_ret0", 4'd15, 0); set_reg(v, 5'd1, 4'd0, 32'h77); step(v);
    v = nop("wrap_issue", 4'd0, 1); v.add = 1; v.rd = 5'd16; step(v);
    v = nop("cmp1_wrap", 4'd0, 1); v.rsU = 1; v.rsI = 1; v.rsV = 32'h11; step(v);
    v = nop("issue_retire", 4'd1, 1); v.add = 1; v.rd = 5'd17; set_reg(v, 5'd2, 4'd1, 32'h11); step(v);

    // Reset from a full buffer, then reset with a retirement pending
    resetIn = 1'b0;
    v = nop("rst_full", 4'd0, 0); step(v);
    resetIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v = nop("pend", 4'(i + 1), 0); v.add = 1; v.rd = 5'(20 + i);
      if (i == 4) begin v.rsU = 1; v.rsI = 0; v.rsV = 32'h42; end
      step(v);
    end
    resetIn = 1'b0;
    v = nop("rst_mid", 4'd0, 0); step(v);
    chk_zero("rst_mid");
    resetIn = 1'b1;
    v = nop("stale3", 4'd0, 0); v.rsU = 1; v.rsI = 3; v.rsV = 32'h33; step(v);
    v = nop("stale_idle1", 4'd0, 0); v.q1 = 3; step(v);
    v = nop("stale_idle2", 4'd0, 0); v.q1 = 3; step(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
`default_nettype wire
